// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, opcode and alu_operation constants, control bundle
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_ANDI  = 3'b101;
  localparam logic [2:0] ALU_ORI   = 3'b111;
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_operation;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;
endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: per-state control outputs (state, op_reg, zero, mem_ready -> ctrl bundle)
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  op_reg,
  input  logic        zero,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_operation = ALU_ADD;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.illegal_op = !(op_reg inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J});
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_operation = ALU_RTYPE;
      end
      RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_operation = ALU_SUB;
        ctrl.pc_source = 2'b01;
        ctrl.pc_write = (op_reg == OP_BEQ && zero) || (op_reg == OP_BNE && !zero);
        ctrl.instr_done = 1'b1;
      end
      IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_operation = op_reg == OP_ANDI ? ALU_ANDI : op_reg == OP_ORI ? ALU_ORI : ALU_ADDI;
      end
      IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_write = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-subset control FSM (clk/reset, opcode/mem_ready/zero in; datapath controls, state, instr_done, illegal_op out)
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_operation,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);
  state_t     cur, nxt;
  logic [5:0] op_reg;
  ctrl_t      c;
  mc_output_decode u_dec (.state(cur), .op_reg(op_reg), .zero(zero), .mem_ready(mem_ready), .ctrl(c));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur <= FETCH;
      op_reg <= '0;
    end else begin
      cur <= nxt;
      if (c.ir_write) op_reg <= opcode;
    end
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: nxt = (op_reg == OP_LW || op_reg == OP_SW) ? MEMADR :
                    op_reg == OP_R ? EXEC :
                    (op_reg == OP_BEQ || op_reg == OP_BNE) ? BRANCH :
                    (op_reg == OP_ADDI || op_reg == OP_ANDI || op_reg == OP_ORI) ? IEXEC :
                    op_reg == OP_J ? JUMP : FETCH;
      MEMADR: nxt = op_reg == OP_LW ? MEMRD : op_reg == OP_SW ? MEMWR : FETCH;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      EXEC:   nxt = RWB;
      IEXEC:  nxt = IWB;
      default: nxt = FETCH;
    endcase
  end
  // reset parks the FSM in FETCH, whose combinational strobes must stay quiet
  assign pc_write      = c.pc_write & ~reset;
  assign ir_write      = c.ir_write & ~reset;
  assign mem_read      = c.mem_read & ~reset;
  assign mem_write     = c.mem_write & ~reset;
  assign reg_write     = c.reg_write & ~reset;
  assign instr_done    = c.instr_done & ~reset;
  assign illegal_op    = c.illegal_op & ~reset;
  assign iord          = c.iord;
  assign reg_dst       = c.reg_dst;
  assign mem_to_reg    = c.mem_to_reg;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign pc_source     = c.pc_source;
  assign alu_operation = c.alu_operation;
  assign state         = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven instruction runs with a scoreboard, plus reset corner cases
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset, mem_ready, zero;
  logic [5:0] opcode;
  logic pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_operation;
  logic [3:0] state;
  logic instr_done, illegal_op;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_operation(alu_operation), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        z;
    int          fw;
    int          waits;
    logic [31:0] trace;
    int          len;
    int          regw;
    int          pcw;
    int          memw;
    int          m2r;
    int          rdst;
    logic [2:0]  aop;
    logic [1:0]  psrc;
    int          ill;
    int          done;
  } vec_t;
  vec_t vecs[13];
  vec_t sb[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    vec_t e;
    int c = 0;
    bit done = 0;
    logic [31:0] tr = '0;
    int regw = 0, pcw = 0, memw = 0, m2r = 0, rdst = 0, ill = 0, dn = 0;
    logic [2:0] aop = '0;
    logic [1:0] psrc = '0;
    sb.push_back(v);
    while (!done && c < 40) begin
      @(negedge clk);
      opcode = (c <= v.fw) ? v.op : ~v.op;
      zero = v.z;
      mem_ready = (c == v.fw) || (c >= v.fw + 3 + v.waits);
      #1;
      if (c < 8) tr[c*4 +: 4] = state;
      regw += int'(reg_write);
      pcw += int'(pc_write);
      memw += int'(mem_write);
      m2r += int'(mem_to_reg);
      rdst += int'(reg_dst);
      ill += int'(illegal_op);
      dn += int'(instr_done);
      if (c == v.fw + 2) begin
        aop = alu_operation;
        psrc = pc_source;
      end
      done = instr_done || illegal_op;
      c++;
    end
    e = sb.pop_front();
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s.timeout: no completion after %0d cycles", e.name, c);
    end
    chk({e.name, ".len"}, c, e.len);
    chk({e.name, ".trace"}, tr, e.trace);
    chk({e.name, ".reg_write"}, regw, e.regw);
    chk({e.name, ".pc_write"}, pcw, e.pcw);
    chk({e.name, ".mem_write"}, memw, e.memw);
    chk({e.name, ".mem_to_reg"}, m2r, e.m2r);
    chk({e.name, ".reg_dst"}, rdst, e.rdst);
    chk({e.name, ".alu_op"}, 32'(aop), 32'(e.aop));
    chk({e.name, ".pc_source"}, 32'(psrc), 32'(e.psrc));
    chk({e.name, ".illegal"}, ill, e.ill);
    chk({e.name, ".done"}, dn, e.done);
  endtask
  initial begin
    vecs[0]  = '{"lw",      6'b100011, 1'b0, 0, 0, 32'h43210,   5, 1, 1, 0, 1, 0, 3'b000, 2'b00, 0, 1};
    vecs[1]  = '{"lw_w2",   6'b100011, 1'b0, 0, 2, 32'h4333210, 7, 1, 1, 0, 1, 0, 3'b000, 2'b00, 0, 1};
    vecs[2]  = '{"sw_w3",   6'b101011, 1'b0, 0, 3, 32'h5555210, 7, 0, 1, 4, 0, 0, 3'b000, 2'b00, 0, 1};
    vecs[3]  = '{"r_fw2",   6'b000000, 1'b0, 2, 0, 32'h761000,  6, 1, 1, 0, 0, 1, 3'b010, 2'b00, 0, 1};
    vecs[4]  = '{"beq_z1",  6'b000100, 1'b1, 0, 0, 32'h810,     3, 0, 2, 0, 0, 0, 3'b001, 2'b01, 0, 1};
    vecs[5]  = '{"beq_z0",  6'b000100, 1'b0, 0, 0, 32'h810,     3, 0, 1, 0, 0, 0, 3'b001, 2'b01, 0, 1};
    vecs[6]  = '{"bne_z0",  6'b000101, 1'b0, 0, 0, 32'h810,     3, 0, 2, 0, 0, 0, 3'b001, 2'b01, 0, 1};
    vecs[7]  = '{"bne_z1",  6'b000101, 1'b1, 0, 0, 32'h810,     3, 0, 1, 0, 0, 0, 3'b001, 2'b01, 0, 1};
    vecs[8]  = '{"addi",    6'b001000, 1'b0, 0, 0, 32'hA910,    4, 1, 1, 0, 0, 0, 3'b100, 2'b00, 0, 1};
    vecs[9]  = '{"andi",    6'b001100, 1'b0, 0, 0, 32'hA910,    4, 1, 1, 0, 0, 0, 3'b101, 2'b00, 0, 1};
    vecs[10] = '{"ori",     6'b001101, 1'b0, 0, 0, 32'hA910,    4, 1, 1, 0, 0, 0, 3'b111, 2'b00, 0, 1};
    vecs[11] = '{"j",       6'b000010, 1'b0, 0, 0, 32'hB10,     3, 0, 2, 0, 0, 0, 3'b000, 2'b10, 0, 1};
    vecs[12] = '{"illegal", 6'b111111, 1'b0, 0, 0, 32'h10,      2, 0, 1, 0, 0, 0, 3'b000, 2'b00, 1, 0};
    reset = 1'b1;
    opcode = '0;
    zero = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst.state", 32'(state), 0);
    chk("rst.mem_read", 32'(mem_read), 0);
    chk("rst.ir_write", 32'(ir_write), 0);
    chk("rst.pc_write", 32'(pc_write), 0);
    chk("rst.alu_src_b", 32'(alu_src_b), 1);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);
    @(negedge clk);
    opcode = 6'b100011;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid.state_memrd", 32'(state), 3);
    chk("mid.mem_read_memrd", 32'(mem_read), 1);
    chk("mid.iord_memrd", 32'(iord), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid.state_async", 32'(state), 0);
    chk("mid.mem_read_async", 32'(mem_read), 0);
    chk("mid.iord_async", 32'(iord), 0);
    chk("mid.reg_write_async", 32'(reg_write), 0);
    chk("mid.done_async", 32'(instr_done), 0);
    @(negedge clk);
    #1;
    chk("mid.state_held", 32'(state), 0);
    reset = 1'b0;
    mem_ready = 1'b0;
    run_vec(vecs[8]);
    run_vec(vecs[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction bits [31:26] from memory read data.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have the following control outputs, 1 bit each unless stated: pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a.
REQ-007 SHALL have outputs alu_src_b (2 bits), pc_source (2 bits) and alu_operation (3 bits): ALU-control op code.
REQ-008 SHALL have outputs state (4 bits, debug), instr_done (1-bit pulse) and illegal_op (1-bit pulse).

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-010 SHALL treat alu_operation codes as fixed: 000 add, 001 sub, 010 R-type (funct-decoded downstream), 100 addi, 101 andi, 111 ori.
REQ-011 SHALL decode these opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, j=000010.
REQ-012 SHALL register opcode into op_reg on the cycle ir_write=1, and use op_reg in all later decode.
REQ-013 In FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_operation=000, pc_source=00; SHALL hold there while mem_ready=0 with ir_write=pc_write=0; when mem_ready=1, SHALL drive ir_write=pc_write=1 and go to DECODE.
REQ-014 In DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_operation=000; next state SHALL be lw/sw->MEMADR, R->EXEC, beq/bne->BRANCH, addi/andi/ori->IEXEC, j->JUMP, other->FETCH with illegal_op=1 for that cycle.
REQ-015 In MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_operation=000; next state SHALL be lw->MEMRD, sw->MEMWR.
REQ-016 In MEMRD SHALL drive mem_read=1, iord=1, and wait for mem_ready, then go to MEMWB; in MEMWR SHALL drive mem_write=1, iord=1, and wait for mem_ready, then go to FETCH.
REQ-017 In MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-018 In EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_operation=010, then go to RWB; in RWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-019 In BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_operation=001, pc_source=01; pc_write SHALL be (beq&zero)|(bne&~zero), combinationally on zero; then go to FETCH.
REQ-020 In IEXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_operation=100/101/111 for addi/andi/ori, then go to IWB; in IWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-021 In JUMP SHALL drive pc_source=10, pc_write=1, then go to FETCH.
REQ-022 SHALL drive every output not listed for a state to 0.
REQ-023 SHALL pulse instr_done for exactly one cycle on each transition to FETCH, except the illegal-op exit.
REQ-024 mem_ready in non-memory states SHALL be ignored; a multi-cycle memory wait SHALL have unbounded length.
REQ-025 Instruction latency SHALL be, with zero wait states: lw 5, sw 4, R 4, addi/andi/ori 4, beq/bne 3, j 3 cycles.

Reset
REQ-026 Reset assertion SHALL force state=FETCH and op_reg=0 immediately, independent of clk.
REQ-027 While reset=1, pc_write, ir_write, mem_read, mem_write, reg_write, instr_done and illegal_op SHALL be 0; all other outputs SHALL take their FETCH values.
REQ-028 Reset asserted mid-instruction SHALL abandon the instruction with no further strobes; the first edge after release SHALL begin in FETCH.

Structure
REQ-029 Package mc_pkg SHALL hold the state enum, the opcode constants and the alu_operation constants, shared with the ALU control decoder.
REQ-030 A combinational sub-module mc_output_decode (state, op_reg, zero, mem_ready -> control outputs) SHALL be used; next-state logic and registers SHALL stay in the top module.

Verification
REQ-031 Verification SHALL cover these directed scenarios:
- lw (100011), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1, mem_to_reg=1 in state 4; instr_done on the return to 0.
- sw (101011), mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 cycles; no reg_write.
- beq with zero=1 -> pc_write=1, pc_source=01 in BRANCH; beq with zero=0 -> pc_write=0; bne inverse.
- ori (001101) -> alu_operation=111 in IEXEC; R-type -> 010 in EXEC, reg_dst=1 in RWB.
- opcode 111111 -> illegal_op pulse in DECODE, back to FETCH, no instr_done.
- reset asserted in MEMRD between edges -> state=0 and strobes 0 at once; the next fetch proceeds normally.
